dm_responder: RTL and testbench
===============================

# dm_responder

Data-memory responder on the M-stage memory interface. It takes word-wide load and store requests from the M-stage control (mem_write, mem_read) and serves them after a configurable number of wait cycles. While a request is outstanding it raises busy, and the hazard unit uses busy to freeze the pipeline. It replaces the zero-latency data memory as the M-stage storage endpoint.

## Interface
Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words. Must be a power of two.
- LATENCY, 1: wait cycles before completion. Legal range is 1 to 15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- mem_write  input  1  store request from the M-stage controller
- mem_read  input  1  load request from the M-stage controller
- addr  input  32  byte address (ALU result)
- wdata  input  32  store data
- pc  input  32  PC of the M-stage instruction, used only for display
- busy  output  1  stall request to the hazard unit
- rvalid  output  1  load data valid this cycle
- rdata  output  32  load data

## Operation
- Request: req = mem_write | mem_read.
  - If both are asserted, the request is treated as a store and the load is ignored.
- FSM has two states: IDLE and WAIT.
- In IDLE with req = 1:
  - Capture addr[31:2], wdata, pc and the request kind.
  - Load cnt = LATENCY-1 and move to WAIT.
  - busy = 1 in this cycle.
- In WAIT with cnt != 0:
  - busy = 1, cnt decrements.
  - The M-stage inputs are ignored. Only captured values are used.
- In WAIT with cnt == 0 (completion cycle):
  - busy = 0.
  - Store: mem[captured index] <= captured wdata at the clock edge.
  - Load: rvalid = 1 and rdata = mem[captured index].
  - Next state is IDLE.
- Outside the completion cycle of a load, rdata = 0 and rvalid = 0.
- busy is combinational: busy = (IDLE & req) | (WAIT & cnt != 0).
- Index is addr[log2(DEPTH_WORDS)+1:2]. addr[1:0] is ignored, so no alignment trap is raised.
- Out of range means addr[31:2] >= DEPTH_WORDS:
  - A store is dropped.
  - A load returns rdata = 0 with rvalid = 1.
  - Timing is unchanged.
- A load reads the array before any write at the same edge can apply. No bypass is needed, because only one request is outstanding at a time.

## Timing
- Reset (reset = 0 at an edge):
  - State = IDLE, cnt = 0, every memory word = 0.
  - busy, rvalid and rdata are 0 after reset.
  - In-flight requests are aborted and pending stores are not committed.
- Latency: a request seen in IDLE at cycle t completes in cycle t+LATENCY. busy is high in cycles t through t+LATENCY-1.
- The pipeline holds the M-stage inputs stable while busy = 1. The instruction leaves M at the end of the completion cycle.
- Back-to-back: the next instruction's request is seen in IDLE at t+LATENCY+1. There is no dead cycle beyond this.
- A non-memory instruction in M (req = 0) in IDLE produces busy = 0 with zero latency.
- cnt is 4 bits wide and never wraps, because LATENCY is at most 15.

## Configuration
- DM_DISPLAY_EN defined:
  - Every committed store that is in range prints `@<pc hex 8>: *<byte addr hex 8> <= <wdata hex 8>` at the commit edge, using $display.
  - Byte addr is the captured index × 4.
  - Dropped stores print nothing.
- DM_DISPLAY_EN undefined: no display code is compiled, and behaviour is otherwise identical.

## Structure
- Shared header head.v holds:
  - FSM state encodings DM_IDLE and DM_WAIT.
  - Default DEPTH_WORDS and LATENCY values.
- One sub-module, dm_array:
  - Synchronous-write, asynchronous-read word array with a synchronous active-low clear.
  - Ports: clk, reset, we, widx, wdata, ridx, rdata.
- dm_responder contains the FSM, the counter, the capture registers, the range check and the display.

## Test plan
- Reset: hold reset = 0 for 2 cycles, then load addr 0x0000_0010 (LATENCY = 1) -> busy = 1 for 1 cycle, then rvalid = 1 with rdata = 0.
- Store then load, LATENCY = 3:
  - Store 0xDEAD_BEEF to 0x0000_0004, pc 0x0000_3000 -> busy high 3 cycles.
  - With the macro defined, prints `@00003000: *00000004 <= deadbeef`.
  - The next load of 0x0000_0004 -> rvalid in its 4th cycle with rdata = 0xDEAD_BEEF.
- Ignored low bits: store 0x1234_5678 to 0x0000_0009 -> a load from 0x0000_0008 returns 0x1234_5678.
- Out of range: store 0xFFFF_FFFF to 0x0000_4000 (DEPTH_WORDS = 4096) -> nothing printed, and a later load of 0x0000_0000 returns 0.
- Reset mid-WAIT, LATENCY = 4: store 0xAAAA_AAAA to 0x20, assert reset in the 2nd busy cycle -> busy = 0 next cycle, and a later load of 0x20 returns 0.
- Both mem_write = 1 and mem_read = 1: store 0x5 to 0x40 -> word written, rvalid stays 0.

Source files
------------

// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   dm_state_t          : FSM state encoding (DM_IDLE / DM_WAIT)
//   DM_DEPTH_WORDS_DEF  : default number of 32-bit words
//   DM_LATENCY_DEF      : default wait cycles before completion
package dm_responder_pkg;

    typedef enum logic {
        DM_IDLE = 1'b0,
        DM_WAIT = 1'b1
    } dm_state_t;

    localparam int DM_DEPTH_WORDS_DEF = 4096;
    localparam int DM_LATENCY_DEF     = 1;

endpackage

// File: rtl/dm_responder_array.sv
// Word array for the data-memory responder: synchronous write, asynchronous
// read, synchronous active-low clear of every word.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low clear
//   we     write enable
//   widx   write word index
//   wdata  write data
//   ridx   read word index
//   rdata  read data (combinational)
module dm_array #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] widx,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] ridx,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    // Read sees the pre-edge contents, so a load never observes a same-edge write.
    assign rdata = mem[ridx];

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the M-stage memory interface. Serves one load or
// store at a time after LATENCY wait cycles, raising busy to freeze the
// pipeline while the request is outstanding.
// Optional macro: DM_DISPLAY_EN prints every committed in-range store.
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   LATENCY      wait cycles before completion (1..15)
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   mem_write  store request
//   mem_read   load request (ignored when mem_write is also set)
//   addr       byte address, addr[1:0] ignored
//   wdata      store data
//   pc         PC of the M-stage instruction (display only)
//   busy       stall request to the hazard unit
//   rvalid     load data valid (completion cycle of a load)
//   rdata      load data, 0 whenever rvalid is low
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DM_DEPTH_WORDS_DEF,
    parameter int LATENCY     = DM_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        rvalid,
    output logic [31:0] rdata
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dm_state_t   state;
    logic [3:0]  cnt;
    logic [29:0] cap_word;
    logic [31:0] cap_wdata;
    logic        cap_store;

    logic        req;
    logic        done;
    logic        in_range;
    logic        we;
    logic [31:0] arr_rdata;

    assign req      = mem_write | mem_read;
    assign done     = (state == DM_WAIT) && (cnt == 4'd0);
    // Any word-address bit at or above AW set means past the end of the array.
    assign in_range = (cap_word >> AW) == 30'd0;
    assign we       = done & cap_store & in_range;

    assign busy   = ((state == DM_IDLE) & req) | ((state == DM_WAIT) & (cnt != 4'd0));
    assign rvalid = done & ~cap_store;
    assign rdata  = (rvalid & in_range) ? arr_rdata : 32'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= DM_IDLE;
            cnt       <= 4'd0;
            cap_word  <= '0;
            cap_wdata <= '0;
            cap_store <= 1'b0;
        end else begin
            case (state)
                DM_IDLE: begin
                    if (req) begin
                        cap_word  <= addr[31:2];
                        cap_wdata <= wdata;
                        cap_store <= mem_write;   // store wins when both are set
                        cnt       <= 4'(LATENCY - 1);
                        state     <= DM_WAIT;
                    end
                end
                DM_WAIT: begin
                    if (cnt != 4'd0) cnt   <= cnt - 4'd1;
                    else             state <= DM_IDLE;
                end
                default: state <= DM_IDLE;
            endcase
        end
    end

    dm_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .widx  (cap_word[AW-1:0]),
        .wdata (cap_wdata),
        .ridx  (cap_word[AW-1:0]),
        .rdata (arr_rdata)
    );

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

`ifdef DM_DISPLAY_EN
    logic [31:0] cap_pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cap_pc <= '0;
        end else begin
            if (state == DM_IDLE && req) cap_pc <= pc;
            if (we) $display("@%08h: *%08h <= %08h", cap_pc, {cap_word, 2'b00}, cap_wdata);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^pc;
`endif

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    localparam int LAT   = 3;
    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_write, mem_read;
    logic [31:0] addr, wdata, pc;
    logic        busy, rvalid;
    logic [31:0] rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];

    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .addr      (addr),
        .wdata     (wdata),
        .pc        (pc),
        .busy      (busy),
        .rvalid    (rvalid),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected load data whenever the DUT presents rvalid.
    always @(negedge clk) begin
        #2;
        if (reset === 1'b1) begin
            if (rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("load_rdata", rdata, e);
                end
            end else begin
                chk("rdata_idle_zero", rdata, 32'd0);
            end
        end
    end

    function automatic bit in_rng(input logic [31:0] a);
        return a[31:2] < DEPTH;
    endfunction

    function automatic logic [11:0] widx(input logic [31:0] a);
        return a[13:2];
    endfunction

    // Issue one M-stage request at a negedge and hold it until the completion
    // cycle has passed, as the stalled pipeline would.
    task automatic issue(input bit w, input bit r, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] p);
        int n;
        if (w) begin
            if (in_rng(a)) model[widx(a)] = d;
        end else if (r) begin
            exp_q.push_back(in_rng(a) ? model[widx(a)] : 32'd0);
        end
        mem_write = w; mem_read = r; addr = a; wdata = d; pc = p;
        n = 0;
        forever begin
            #1;
            if (!busy) break;
            n++;
            if (n > 40) break;
            @(negedge clk);
        end
        chk("busy_cycles", n, LAT);
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b0;
    endtask

    task automatic idle_cycle();
        mem_write = 1'b0; mem_read = 1'b0; addr = $urandom;
        #1;
        chk("idle_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    endtask

    initial begin
        reset = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
        addr = '0; wdata = '0; pc = '0;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset_busy",   {31'd0, busy},   32'd0);
        chk("reset_rvalid", {31'd0, rvalid}, 32'd0);
        chk("reset_rdata",  rdata,           32'd0);
        @(negedge clk);

        // Load after reset returns zero.
        issue(1'b0, 1'b1, 32'h0000_0010, 32'd0, 32'h100);
        // Store then load back.
        issue(1'b1, 1'b0, 32'h0000_0004, 32'hDEAD_BEEF, 32'h3000);
        issue(1'b0, 1'b1, 32'h0000_0004, 32'd0, 32'h3004);
        // Low address bits ignored.
        issue(1'b1, 1'b0, 32'h0000_0009, 32'h1234_5678, 32'h3008);
        issue(1'b0, 1'b1, 32'h0000_0008, 32'd0, 32'h300C);
        // Out-of-range store dropped; word 0 stays zero; out-of-range load gives 0.
        issue(1'b1, 1'b0, 32'h0000_4000, 32'hFFFF_FFFF, 32'h3010);
        issue(1'b0, 1'b1, 32'h0000_0000, 32'd0, 32'h3014);
        issue(1'b0, 1'b1, 32'h0000_4000, 32'd0, 32'h3018);
        // Both flags: treated as store, no rvalid.
        issue(1'b1, 1'b1, 32'h0000_0040, 32'h0000_0005, 32'h301C);
        issue(1'b0, 1'b1, 32'h0000_0040, 32'd0, 32'h3020);
        idle_cycle();

        // Randomized mix over a small window so loads hit earlier stores.
        for (int k = 0; k < 200; k++) begin
            logic [31:0] a;
            int kind;
            kind = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h0000_4000;
            else a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom)};
            if (kind < 4)       issue(1'b1, 1'b0, a, $urandom, 32'h4000 + 32'(k));
            else if (kind < 8)  issue(1'b0, 1'b1, a, $urandom, 32'h4000 + 32'(k));
            else if (kind == 8) issue(1'b1, 1'b1, a, $urandom, 32'h4000 + 32'(k));
            else                idle_cycle();
        end

        // Store to 0x20, then reset during the second busy cycle.
        issue(1'b1, 1'b0, 32'h0000_0020, 32'h0BAD_F00D, 32'h5000);
        mem_write = 1'b1; mem_read = 1'b0; addr = 32'h20; wdata = 32'hAAAA_AAAA; pc = 32'h5004;
        #1;
        chk("midreset_busy_start", {31'd0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        clear_model();
        #1;
        chk("midreset_busy_after",   {31'd0, busy},   32'd0);
        chk("midreset_rvalid_after", {31'd0, rvalid}, 32'd0);
        @(negedge clk);
        issue(1'b0, 1'b1, 32'h0000_0020, 32'd0, 32'h5008);
        for (int k = 0; k < 8; k++)
            issue(1'b0, 1'b1, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, 32'd0, 32'h500C);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
